axi_lite_master_selftest: RTL and testbench

//  Parametrised AXI4-Lite master self-test engine; successor to the fixed-pattern simple master.
//  On INIT_AXI_TXN it writes C_M_TRANSACTIONS_NUM words to a slave, reads them back and compares.

---
 rtl/axi_lite_master_selftest_if.sv | 37 +++
 rtl/axi_lite_master_selftest.sv | 190 +++++++++++++++++++
 tb/tb_axi_lite_master_selftest.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_master_selftest_if.sv
// AXI4-Lite bus bundle between the self-test master and its slave port.
interface axi_lite_master_selftest_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic [AW-1:0]   awaddr;
    logic [2:0]      awprot;
    logic            awvalid;
    logic            awready;
    logic [DW-1:0]   wdata;
    logic [DW/8-1:0] wstrb;
    logic            wvalid;
    logic            wready;
    logic [1:0]      bresp;
    logic            bvalid;
    logic            bready;
    logic [AW-1:0]   araddr;
    logic [2:0]      arprot;
    logic            arvalid;
    logic            arready;
    logic [DW-1:0]   rdata;
    logic [1:0]      rresp;
    logic            rvalid;
    logic            rready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi_lite_master_selftest.sv
// AXI4-Lite self-test master: writes a pattern to N words, reads it back and counts errors.
// state  | meaning
// IDLE   | out of reset, waiting for first start
// WRITE  | issuing AW/W beats and collecting B responses for words 0..N-1
// READ   | issuing AR beats and comparing R data for words 0..N-1
// DONE   | run finished or aborted by watchdog; TXN_DONE high until next start
module axi_lite_master_selftest #(
    parameter logic [31:0] C_M_TARGET_SLAVE_BASE_ADDR = 32'h4000_0000,
    parameter int          C_M_AXI_ADDR_WIDTH         = 32,
    parameter int          C_M_AXI_DATA_WIDTH         = 32,
    parameter int          C_M_TRANSACTIONS_NUM       = 4,
    parameter logic [31:0] C_M_START_DATA_VALUE       = 32'hAA00_0000,
    parameter int          C_M_TIMEOUT                = 1024
) (
    input  logic        M_AXI_ACLK,
    input  logic        M_AXI_ARESETN,
    input  logic        INIT_AXI_TXN,
    input  logic [1:0]  MODE,
    output logic        TXN_DONE,
    output logic        ERROR,
    output logic [15:0] ERR_COUNT,
    axi_lite_master_selftest_if.master m_axi
);
    localparam int AW         = C_M_AXI_ADDR_WIDTH;
    localparam int DW         = C_M_AXI_DATA_WIDTH;
    localparam int N          = C_M_TRANSACTIONS_NUM;
    localparam int IW         = (N > 1) ? $clog2(N) : 1;
    localparam int TW         = $clog2(C_M_TIMEOUT + 1);
    localparam int BYTE_SHIFT = $clog2(DW / 8);

    typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_READ, ST_DONE} state_t;

    state_t          state, state_nxt;
    logic            init_q;
    logic            start, last, any_hs, timeout, err_event;
    logic            aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic            awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
    logic [IW-1:0]   idx;
    logic [TW-1:0]   wd_cnt;
    logic [1:0]      mode_q;
    logic [DW-1:0]   seq_val, pattern;
    logic [AW-1:0]   addr_cur;
    logic            unused_resp;

    assign aw_hs  = awvalid_q & m_axi.awready;
    assign w_hs   = wvalid_q  & m_axi.wready;
    assign b_hs   = bready_q  & m_axi.bvalid;
    assign ar_hs  = arvalid_q & m_axi.arready;
    assign r_hs   = rready_q  & m_axi.rvalid;
    assign any_hs = aw_hs | w_hs | b_hs | ar_hs | r_hs;

    assign start   = INIT_AXI_TXN & ~init_q & ((state == ST_IDLE) | (state == ST_DONE));
    assign last    = (idx == IW'(N - 1));
    assign timeout = ((state == ST_WRITE) | (state == ST_READ)) & ~any_hs
                     & (wd_cnt == TW'(C_M_TIMEOUT - 1));

    always_comb begin
        seq_val = DW'(C_M_START_DATA_VALUE) + DW'(idx);
        case (mode_q)
            2'd1:    pattern = ~seq_val;
            2'd2:    pattern = DW'(1) << (32'(idx) % DW);
            default: pattern = seq_val;
        endcase
    end

    assign addr_cur = AW'(C_M_TARGET_SLAVE_BASE_ADDR) + (AW'(idx) << BYTE_SHIFT);

    // A bad RRESP and a data mismatch on the same beat collapse into one event.
    assign err_event = ((state == ST_WRITE) & b_hs & m_axi.bresp[1])
                     | ((state == ST_READ) & r_hs & (m_axi.rresp[1] | (m_axi.rdata != pattern)))
                     | timeout;

    assign m_axi.awaddr  = addr_cur;
    assign m_axi.araddr  = addr_cur;
    assign m_axi.wdata   = pattern;
    assign m_axi.awprot  = 3'b000;
    assign m_axi.arprot  = 3'b000;
    assign m_axi.wstrb   = '1;
    assign m_axi.awvalid = awvalid_q;
    assign m_axi.wvalid  = wvalid_q;
    assign m_axi.bready  = bready_q;
    assign m_axi.arvalid = arvalid_q;
    assign m_axi.rready  = rready_q;
    assign unused_resp   = m_axi.bresp[0] ^ m_axi.rresp[0];

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            state  <= ST_IDLE;
            init_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            init_q <= INIT_AXI_TXN;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start) state_nxt = ST_WRITE;
            ST_WRITE: begin
                if (timeout)          state_nxt = ST_DONE;
                else if (b_hs & last) state_nxt = ST_READ;
            end
            ST_READ: begin
                if (timeout)          state_nxt = ST_DONE;
                else if (r_hs & last) state_nxt = ST_DONE;
            end
            ST_DONE:  if (start) state_nxt = ST_WRITE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            idx       <= '0;
            wd_cnt    <= '0;
            mode_q    <= 2'd0;
            TXN_DONE  <= 1'b0;
            ERROR     <= 1'b0;
            ERR_COUNT <= 16'd0;
        end else if (start) begin
            mode_q    <= MODE;
            ERROR     <= 1'b0;
            ERR_COUNT <= 16'd0;
            TXN_DONE  <= 1'b0;
            idx       <= '0;
            wd_cnt    <= '0;
            awvalid_q <= 1'b1;
            wvalid_q  <= 1'b1;
            bready_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
        end else begin
            if (err_event) begin
                ERROR <= 1'b1;
                if (ERR_COUNT != 16'hFFFF) ERR_COUNT <= ERR_COUNT + 16'd1;
            end
            if (any_hs)
                wd_cnt <= '0;
            else if ((state == ST_WRITE) | (state == ST_READ))
                wd_cnt <= wd_cnt + 1'b1;

            if (timeout) begin
                awvalid_q <= 1'b0;
                wvalid_q  <= 1'b0;
                bready_q  <= 1'b0;
                arvalid_q <= 1'b0;
                rready_q  <= 1'b0;
                TXN_DONE  <= 1'b1;
                wd_cnt    <= '0;
            end else if (state == ST_WRITE) begin
                if (aw_hs) awvalid_q <= 1'b0;
                if (w_hs)  wvalid_q  <= 1'b0;
                // BREADY rises once, on the edge where the later of AW/W completes.
                if ((awvalid_q | wvalid_q) & (aw_hs | ~awvalid_q) & (w_hs | ~wvalid_q))
                    bready_q <= 1'b1;
                if (b_hs) begin
                    bready_q <= 1'b0;
                    if (last) begin
                        idx       <= '0;
                        arvalid_q <= 1'b1;
                    end else begin
                        idx       <= idx + 1'b1;
                        awvalid_q <= 1'b1;
                        wvalid_q  <= 1'b1;
                    end
                end
            end else if (state == ST_READ) begin
                if (ar_hs) begin
                    arvalid_q <= 1'b0;
                    rready_q  <= 1'b1;
                end
                if (r_hs) begin
                    rready_q <= 1'b0;
                    if (last) begin
                        TXN_DONE <= 1'b1;
                    end else begin
                        idx       <= idx + 1'b1;
                        arvalid_q <= 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_axi_lite_master_selftest.sv
// Bench for axi_lite_master_selftest: two instances (N=4 and N=40) share one memory slave model.
module tb_axi_lite_master_selftest;
    logic        tb_ACLK = 1'b0;
    logic        rst_n;
    logic        sel;
    logic        init_a, init_b;
    logic [1:0]  mode_a, mode_b;
    logic        done_a, done_b, err_a, err_b;
    logic [15:0] cnt_a, cnt_b;

    int n_checks = 0;
    int n_errors = 0;

    always #5 tb_ACLK = ~tb_ACLK;

    axi_lite_master_selftest_if #(.AW(32), .DW(32)) if_a ();
    axi_lite_master_selftest_if #(.AW(32), .DW(32)) if_b ();

    axi_lite_master_selftest #(.C_M_TRANSACTIONS_NUM(4), .C_M_TIMEOUT(16)) u_dut_a (
        .M_AXI_ACLK(tb_ACLK), .M_AXI_ARESETN(rst_n), .INIT_AXI_TXN(init_a), .MODE(mode_a),
        .TXN_DONE(done_a), .ERROR(err_a), .ERR_COUNT(cnt_a), .m_axi(if_a)
    );

    axi_lite_master_selftest #(.C_M_TRANSACTIONS_NUM(40), .C_M_TIMEOUT(16)) u_dut_b (
        .M_AXI_ACLK(tb_ACLK), .M_AXI_ARESETN(rst_n), .INIT_AXI_TXN(init_b), .MODE(mode_b),
        .TXN_DONE(done_b), .ERROR(err_b), .ERR_COUNT(cnt_b), .m_axi(if_b)
    );

    // Slave model, attached to whichever master sel picks.
    logic        s_awready, s_wready, s_bvalid, s_arready, s_rvalid;
    logic [1:0]  s_bresp, s_rresp;
    logic [31:0] s_rdata;
    logic        aw_got, w_got;
    logic [31:0] aw_addr_q, w_data_q;
    logic [31:0] mem [0:255];
    logic [31:0] wa_log [0:63];
    int          aw_wait, w_wait;
    int          aw_beats, w_beats, b_beats, r_beats;
    int          aw_delay = 0, w_delay = 0, slverr_idx = -1, corrupt_idx = -1;
    bit          ar_block = 1'b0;

    logic        m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready;
    logic [31:0] m_awaddr, m_wdata, m_araddr;

    assign m_awvalid = sel ? if_b.awvalid : if_a.awvalid;
    assign m_wvalid  = sel ? if_b.wvalid  : if_a.wvalid;
    assign m_bready  = sel ? if_b.bready  : if_a.bready;
    assign m_arvalid = sel ? if_b.arvalid : if_a.arvalid;
    assign m_rready  = sel ? if_b.rready  : if_a.rready;
    assign m_awaddr  = sel ? if_b.awaddr  : if_a.awaddr;
    assign m_wdata   = sel ? if_b.wdata   : if_a.wdata;
    assign m_araddr  = sel ? if_b.araddr  : if_a.araddr;

    assign if_a.awready = s_awready & ~sel;
    assign if_a.wready  = s_wready  & ~sel;
    assign if_a.bvalid  = s_bvalid  & ~sel;
    assign if_a.arready = s_arready & ~sel;
    assign if_a.rvalid  = s_rvalid  & ~sel;
    assign if_b.awready = s_awready & sel;
    assign if_b.wready  = s_wready  & sel;
    assign if_b.bvalid  = s_bvalid  & sel;
    assign if_b.arready = s_arready & sel;
    assign if_b.rvalid  = s_rvalid  & sel;
    assign if_a.bresp = s_bresp;
    assign if_b.bresp = s_bresp;
    assign if_a.rresp = s_rresp;
    assign if_b.rresp = s_rresp;
    assign if_a.rdata = s_rdata;
    assign if_b.rdata = s_rdata;

    always @(posedge tb_ACLK or negedge rst_n) begin
        if (!rst_n) begin
            s_awready <= 0; s_wready <= 0; s_bvalid <= 0; s_arready <= 0; s_rvalid <= 0;
            s_bresp <= 0; s_rresp <= 0; s_rdata <= 0;
            aw_got <= 0; w_got <= 0; aw_addr_q <= 0; w_data_q <= 0;
            aw_wait <= 0; w_wait <= 0;
            aw_beats <= 0; w_beats <= 0; b_beats <= 0; r_beats <= 0;
        end else begin
            if (m_awvalid && s_awready) begin
                s_awready <= 0; aw_got <= 1; aw_addr_q <= m_awaddr;
                aw_beats <= aw_beats + 1; aw_wait <= 0;
            end else if (m_awvalid && !aw_got && !s_awready) begin
                if (aw_wait >= aw_delay) s_awready <= 1;
                else aw_wait <= aw_wait + 1;
            end
            if (m_wvalid && s_wready) begin
                s_wready <= 0; w_got <= 1; w_data_q <= m_wdata;
                w_beats <= w_beats + 1; w_wait <= 0;
            end else if (m_wvalid && !w_got && !s_wready) begin
                if (w_wait >= w_delay) s_wready <= 1;
                else w_wait <= w_wait + 1;
            end
            if (s_bvalid && m_bready) begin
                s_bvalid <= 0;
                b_beats  <= b_beats + 1;
            end else if (aw_got && w_got && !s_bvalid) begin
                s_bvalid <= 1;
                s_bresp  <= (int'(aw_addr_q[9:2]) == slverr_idx) ? 2'b10 : 2'b00;
                mem[aw_addr_q[9:2]] <= w_data_q;
                wa_log[b_beats % 64] <= aw_addr_q;
                aw_got <= 0; w_got <= 0;
            end
            if (m_arvalid && s_arready) begin
                s_arready <= 0; s_rvalid <= 1; s_rresp <= 2'b00;
                s_rdata <= mem[m_araddr[9:2]]
                           ^ ((int'(m_araddr[9:2]) == corrupt_idx) ? 32'd1 : 32'd0);
            end else if (m_arvalid && !s_arready && !s_rvalid && !ar_block) begin
                s_arready <= 1;
            end
            if (s_rvalid && m_rready) begin
                s_rvalid <= 0;
                r_beats  <= r_beats + 1;
            end
        end
    end

    task automatic run_dut(input bit use_b, input logic [1:0] mode, output bit ok);
        @(negedge tb_ACLK);
        sel = use_b;
        if (use_b) begin mode_b = mode; init_b = 1'b1; end
        else       begin mode_a = mode; init_a = 1'b1; end
        repeat (2) @(negedge tb_ACLK);
        init_a = 1'b0;
        init_b = 1'b0;
        ok = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if ((use_b ? done_b : done_a) === 1'b1) begin ok = 1'b1; break; end
            @(negedge tb_ACLK);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; sel = 1'b0;
        init_a = 1'b0; init_b = 1'b0; mode_a = 2'd0; mode_b = 2'd0;
        repeat (3) @(negedge tb_ACLK);
        n_checks++;
        if ({done_a, err_a, cnt_a} !== 18'd0) begin
            n_errors++; $display("FAIL reset_status: got done=%b err=%b cnt=%0d want 0/0/0", done_a, err_a, cnt_a);
        end
        n_checks++;
        if ({if_a.awvalid, if_a.wvalid, if_a.bready, if_a.arvalid, if_a.rready} !== 5'b0) begin
            n_errors++; $display("FAIL reset_handshake: got %b want 00000",
                {if_a.awvalid, if_a.wvalid, if_a.bready, if_a.arvalid, if_a.rready});
        end
        n_checks++;
        if ({if_a.awprot, if_a.arprot, if_a.wstrb} !== 10'b000_000_1111) begin
            n_errors++; $display("FAIL reset_const: got prot=%b/%b strb=%h want 0/0/f", if_a.awprot, if_a.arprot, if_a.wstrb);
        end
        rst_n = 1'b1;
        repeat (3) @(negedge tb_ACLK);
        n_checks++;
        if ({done_a, if_a.awvalid, if_b.awvalid} !== 3'b000) begin
            n_errors++; $display("FAIL idle_after_reset: got %b want 000", {done_a, if_a.awvalid, if_b.awvalid});
        end
    endtask

    task automatic test_mode0();
        bit ok;
        int b0, r0;
        b0 = b_beats; r0 = r_beats;
        run_dut(1'b0, 2'd0, ok);
        n_checks++;
        if (!ok) begin n_errors++; $display("FAIL mode0_done: got timeout want TXN_DONE"); end
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (wa_log[(b0 + k) % 64] !== 32'h4000_0000 + 32'(4 * k)) begin
                n_errors++; $display("FAIL mode0_addr%0d: got %h want %h", k, wa_log[(b0 + k) % 64], 32'h4000_0000 + 32'(4 * k));
            end
            n_checks++;
            if (mem[k] !== 32'hAA00_0000 + 32'(k)) begin
                n_errors++; $display("FAIL mode0_data%0d: got %h want %h", k, mem[k], 32'hAA00_0000 + 32'(k));
            end
        end
        n_checks++;
        if ({err_a, cnt_a} !== 17'd0) begin
            n_errors++; $display("FAIL mode0_err: got err=%b cnt=%0d want 0/0", err_a, cnt_a);
        end
        n_checks++;
        if ((b_beats - b0 !== 4) || (r_beats - r0 !== 4)) begin
            n_errors++; $display("FAIL mode0_beats: got b=%0d r=%0d want 4/4", b_beats - b0, r_beats - r0);
        end
    endtask

    task automatic test_mode1();
        bit ok;
        run_dut(1'b0, 2'd1, ok);
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (mem[k] !== ~(32'hAA00_0000 + 32'(k))) begin
                n_errors++; $display("FAIL mode1_data%0d: got %h want %h", k, mem[k], ~(32'hAA00_0000 + 32'(k)));
            end
        end
        n_checks++;
        if (!ok || cnt_a !== 16'd0) begin
            n_errors++; $display("FAIL mode1_status: got done=%b cnt=%0d want 1/0", ok, cnt_a);
        end
    endtask

    task automatic test_walking();
        bit ok;
        int bad;
        run_dut(1'b1, 2'd2, ok);
        n_checks++;
        if (mem[33] !== 32'h0000_0002) begin
            n_errors++; $display("FAIL walk_word33: got %h want 00000002", mem[33]);
        end
        bad = 0;
        for (int k = 0; k < 40; k++) if (mem[k] !== (32'd1 << (k % 32))) bad++;
        n_checks++;
        if (bad != 0) begin n_errors++; $display("FAIL walk_words: got %0d bad words want 0", bad); end
        n_checks++;
        if (!ok || {err_b, cnt_b} !== 17'd0) begin
            n_errors++; $display("FAIL walk_status: got done=%b err=%b cnt=%0d want 1/0/0", ok, err_b, cnt_b);
        end
    endtask

    task automatic test_errors();
        bit ok;
        slverr_idx = 1; corrupt_idx = 2;
        run_dut(1'b0, 2'd0, ok);
        n_checks++;
        if (!ok || err_a !== 1'b1 || cnt_a !== 16'd2) begin
            n_errors++; $display("FAIL err_inject: got done=%b err=%b cnt=%0d want 1/1/2", ok, err_a, cnt_a);
        end
        slverr_idx = -1; corrupt_idx = -1;
        run_dut(1'b0, 2'd0, ok);
        n_checks++;
        if (!ok || err_a !== 1'b0 || cnt_a !== 16'd0) begin
            n_errors++; $display("FAIL err_cleared: got done=%b err=%b cnt=%0d want 1/0/0", ok, err_a, cnt_a);
        end
    endtask

    task automatic test_out_of_order();
        bit ok;
        int a0, w0, b0;
        for (int p = 0; p < 2; p++) begin
            aw_delay = (p == 0) ? 5 : 0;
            w_delay  = (p == 0) ? 0 : 5;
            a0 = aw_beats; w0 = w_beats; b0 = b_beats;
            run_dut(1'b0, 2'd0, ok);
            n_checks++;
            if (aw_beats - a0 !== 4 || w_beats - w0 !== 4 || b_beats - b0 !== 4) begin
                n_errors++; $display("FAIL order%0d_beats: got aw=%0d w=%0d b=%0d want 4/4/4",
                    p, aw_beats - a0, w_beats - w0, b_beats - b0);
            end
            n_checks++;
            if (!ok || cnt_a !== 16'd0 || mem[3] !== 32'hAA00_0003) begin
                n_errors++; $display("FAIL order%0d_status: got done=%b cnt=%0d mem3=%h want 1/0/aa000003", p, ok, cnt_a, mem[3]);
            end
        end
        aw_delay = 0; w_delay = 0;
    endtask

    task automatic test_timeout();
        int c;
        ar_block = 1'b1;
        @(negedge tb_ACLK);
        sel = 1'b0; mode_a = 2'd0; init_a = 1'b1;
        repeat (2) @(negedge tb_ACLK);
        init_a = 1'b0;
        c = 0;
        while (if_a.arvalid !== 1'b1 && c < 300) begin c++; @(negedge tb_ACLK); end
        c = 0;
        while (if_a.arvalid === 1'b1 && c < 100) begin c++; @(negedge tb_ACLK); end
        n_checks++;
        if (c != 16) begin n_errors++; $display("FAIL timeout_len: got %0d cycles of ARVALID want 16", c); end
        n_checks++;
        if (done_a !== 1'b1 || err_a !== 1'b1 || cnt_a !== 16'd1 || if_a.rready !== 1'b0) begin
            n_errors++; $display("FAIL timeout_status: got done=%b err=%b cnt=%0d rready=%b want 1/1/1/0",
                done_a, err_a, cnt_a, if_a.rready);
        end
        ar_block = 1'b0;
    endtask

    task automatic test_reset_midrun();
        int b0;
        bit ok;
        aw_delay = 10;
        @(negedge tb_ACLK);
        sel = 1'b0; mode_a = 2'd0; init_a = 1'b1;
        repeat (2) @(negedge tb_ACLK);
        init_a = 1'b0;
        @(negedge tb_ACLK);
        n_checks++;
        if (if_a.awvalid !== 1'b1) begin n_errors++; $display("FAIL midrun_inwrite: got awvalid=%b want 1", if_a.awvalid); end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({done_a, err_a, cnt_a, if_a.awvalid, if_a.wvalid, if_a.bready, if_a.arvalid, if_a.rready} !== 23'd0) begin
            n_errors++; $display("FAIL midrun_reset: got done=%b err=%b cnt=%0d hs=%b want all 0", done_a, err_a, cnt_a,
                {if_a.awvalid, if_a.wvalid, if_a.bready, if_a.arvalid, if_a.rready});
        end
        repeat (2) @(negedge tb_ACLK);
        rst_n = 1'b1;
        aw_delay = 0;
        @(negedge tb_ACLK);
        b0 = b_beats;
        init_a = 1'b1;
        repeat (4) @(negedge tb_ACLK);
        init_a = 1'b0;
        @(negedge tb_ACLK);
        init_a = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 500; c++) begin
            if (done_a === 1'b1) begin ok = 1'b1; break; end
            @(negedge tb_ACLK);
        end
        n_checks++;
        if (!ok || b_beats - b0 !== 4 || cnt_a !== 16'd0) begin
            n_errors++; $display("FAIL midrun_rerun: got done=%b b=%0d cnt=%0d want 1/4/0", ok, b_beats - b0, cnt_a);
        end
        repeat (10) @(negedge tb_ACLK);
        n_checks++;
        if (done_a !== 1'b1 || b_beats - b0 !== 4) begin
            n_errors++; $display("FAIL init_held: got done=%b b=%0d want 1/4", done_a, b_beats - b0);
        end
        init_a = 1'b0;
    endtask

    initial begin
        test_reset();
        test_mode0();
        test_mode1();
        test_walking();
        test_errors();
        test_out_of_order();
        test_timeout();
        test_reset_midrun();
        repeat (2) @(negedge tb_ACLK);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
